// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub, iterative shift (one bit per cycle)
// and shift-add multiply (one multiplier bit per cycle), with valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | shifting one bit position per cycle
// MUL   | shift-add multiply, one multiplier bit per cycle
// DONE  | result/flags held until out_ready
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    localparam logic [WIDTH:0] WIDTH_X = (WIDTH+1)'(WIDTH);

    state_t               state;
    logic [CNTW-1:0]      cnt_q;
    logic [WIDTH-1:0]     sh_q;
    logic                 dir_left_q;
    logic                 over_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;

    logic [WIDTH:0]       op2_ext;
    logic [WIDTH:0]       shamt;
    logic [CNTW-1:0]      sh_iter;
    logic [WIDTH:0]       sum_add;
    logic [WIDTH:0]       sum_sub;
    logic [WIDTH-1:0]     sh_next;
    logic                 sh_out;
    logic [WIDTH:0]       mac;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_c;
    logic                 finish;

    // Shift magnitude needs WIDTH+1 bits so the most-negative amount stays positive.
    assign op2_ext = {operand2[WIDTH-1], operand2};
    assign shamt   = operand2[WIDTH-1] ? -op2_ext : op2_ext;
    assign sh_iter = (shamt > WIDTH_X) ? CNTW'(WIDTH) : CNTW'(shamt);

    assign sum_add = {1'b0, operand1} + {1'b0, operand2};
    assign sum_sub = {1'b0, operand1} + {1'b0, ~operand2} + (WIDTH+1)'(1);

    assign sh_next = dir_left_q ? (sh_q << 1) : (sh_q >> 1);
    assign sh_out  = dir_left_q ? sh_q[WIDTH-1] : sh_q[0];

    assign mac       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_next = {mac, prod_q[WIDTH-1:1]};

    always_comb begin
        fin_res = '0;
        fin_c   = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                finish = in_valid && (operation != 3'b001) &&
                         !((operation == 3'b000) && (shamt != '0));
                case (operation)
                    3'b000: fin_res = operand1;
                    3'b010: {fin_c, fin_res} = sum_sub;
                    3'b011: fin_res = operand1 ^ operand2;
                    3'b100: {fin_c, fin_res} = sum_add;
                    3'b101: fin_res = operand1 & operand2;
                    3'b110: fin_res = operand1 | operand2;
                    3'b111: fin_res = ~operand1;
                    default: fin_res = '0;
                endcase
            end
            SHIFT: begin
                finish  = (cnt_q == CNTW'(1));
                fin_res = sh_next;
                // Past WIDTH positions the last bit out is one of the zero fills.
                fin_c   = over_q ? 1'b0 : sh_out;
            end
            MUL: begin
                finish  = (cnt_q == CNTW'(1));
                fin_res = prod_next[WIDTH-1:0];
                fin_c   = |prod_next[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_c     <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            dir_left_q <= 1'b0;
            over_q     <= 1'b0;
            prod_q     <= '0;
            mcand_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (operation == 3'b001) begin
                            state   <= MUL;
                            cnt_q   <= CNTW'(WIDTH);
                            prod_q  <= {{WIDTH{1'b0}}, operand2};
                            mcand_q <= operand1;
                        end else if (!finish) begin
                            state      <= SHIFT;
                            cnt_q      <= sh_iter;
                            sh_q       <= operand1;
                            dir_left_q <= ~operand2[WIDTH-1];
                            over_q     <= (shamt > WIDTH_X);
                        end
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - CNTW'(1);
                end
                MUL: begin
                    prod_q <= prod_next;
                    cnt_q  <= cnt_q - CNTW'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= fin_res;
                flag_z    <= (fin_res == '0);
                flag_n    <= fin_res[WIDTH-1];
                flag_c    <= fin_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, random ops against an arithmetic model,
// backpressure and reset-abort sequences; a second WIDTH=8 instance for regression.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iv;
    logic        ordy;
    logic [2:0]  op_d;
    logic [63:0] a_d, b_d;
    bit          sel8;

    logic        iv16, ir16, ov16, z16, n16, c16;
    logic [15:0] r16;
    logic        iv8, ir8, ov8, z8, n8, c8;
    logic [7:0]  r8;

    logic              cur_ready, cur_valid, cur_z, cur_n, cur_c;
    longint unsigned   cur_res;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign iv16 = iv & ~sel8;
    assign iv8  = iv & sel8;
    assign cur_ready = sel8 ? ir8 : ir16;
    assign cur_valid = sel8 ? ov8 : ov16;
    assign cur_res   = sel8 ? 64'(r8) : 64'(r16);
    assign cur_z     = sel8 ? z8 : z16;
    assign cur_n     = sel8 ? n8 : n16;
    assign cur_c     = sel8 ? c8 : c16;

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
        .operand1(a_d[15:0]), .operand2(b_d[15:0]), .operation(op_d),
        .out_valid(ov16), .out_ready(ordy), .result(r16),
        .flag_z(z16), .flag_n(n16), .flag_c(c16)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .operand1(a_d[7:0]), .operand2(b_d[7:0]), .operation(op_d),
        .out_valid(ov8), .out_ready(ordy), .result(r8),
        .flag_z(z8), .flag_n(n8), .flag_c(c8)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: result, carry and latency straight from the arithmetic definitions.
    function automatic void model(input int w, input logic [2:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned res, output bit c, output int lat);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned k, p;
        bit neg;
        res = 0; c = 0; lat = 1;
        case (op)
            3'd0: begin
                neg = b[w-1];
                k = neg ? ((~b + 1) & mask) : b;
                lat = 1 + int'((k > w) ? w : k);
                if (!neg) begin
                    res = (k >= w) ? 0 : ((a << k) & mask);
                    c = (k >= 1 && k <= w) ? a[w-k] : 1'b0;
                end else begin
                    res = (k >= w) ? 0 : (a >> k);
                    c = (k >= 1 && k <= w) ? a[k-1] : 1'b0;
                end
            end
            3'd1: begin
                p = a * b;
                res = p & mask;
                c = (p >> w) != 0;
                lat = 1 + w;
            end
            3'd2: begin res = (a - b) & mask; c = (a >= b); end
            3'd3: res = a ^ b;
            3'd4: begin p = a + b; res = p & mask; c = (p > mask); end
            3'd5: res = a & b;
            3'd6: res = a | b;
            default: res = ~a & mask;
        endcase
    endfunction

    task automatic run_op(input int w, input logic [2:0] op, input longint unsigned a,
                          input longint unsigned b, input int hold, input longint unsigned er,
                          input bit ec, input int el, input string name);
        int lat;
        bit busy_bad, hold_bad;
        longint unsigned r0;
        sel8 = (w == 8);
        @(negedge clk);
        iv = 1'b1; op_d = op; a_d = a; b_d = b; ordy = 1'b0;
        for (int i = 0; i < 50 && !cur_ready; i++) @(negedge clk);
        check({name, " ready"}, cur_ready, 1);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; a_d = {$urandom, $urandom}; b_d = {$urandom, $urandom}; op_d = 3'($urandom);
        lat = 1; busy_bad = 0;
        while (!cur_valid && lat < 200) begin
            if (cur_ready) busy_bad = 1;
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, el);
        check({name, " result"}, cur_res, er);
        check({name, " c"}, cur_c, ec);
        check({name, " z"}, cur_z, er == 0);
        check({name, " n"}, cur_n, (er >> (w - 1)) & 1);
        check({name, " busy in_ready"}, busy_bad, 0);
        r0 = cur_res; hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!cur_valid || cur_ready || cur_res != r0 || cur_c != ec ||
                cur_z != (er == 0)) hold_bad = 1;
        end
        if (hold > 0) check({name, " hold"}, hold_bad, 0);
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        check({name, " handoff"}, {cur_valid, cur_ready}, 2'b01);
    endtask

    typedef struct {
        logic [2:0]      op;
        longint unsigned a, b, res;
        bit              c;
        int              lat, hold;
    } vec_t;

    vec_t tbl[20];

    initial begin
        longint unsigned er, ra, rb;
        bit ec, ov_seen;
        int el, rop;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        longint unsigned er, ra, rb;
        bit ec, ov_seen;
        int el;
        logic [2:0] rop;

        tbl[0]  = '{3'd4, 64'hFFFF, 64'h0001, 64'h0000, 1'b1, 1, 0};
        tbl[1]  = '{3'd0, 64'h8001, 64'hFFFF, 64'h4000, 1'b1, 2, 0};
        tbl[2]  = '{3'd0, 64'h8001, 64'h0004, 64'h0010, 1'b0, 5, 0};
        tbl[3]  = '{3'd0, 64'h8001, 64'h8000, 64'h0000, 1'b0, 17, 0};
        tbl[4]  = '{3'd1, 64'h0100, 64'h0100, 64'h0000, 1'b1, 17, 0};
        tbl[5]  = '{3'd1, 64'h00FF, 64'h0002, 64'h01FE, 1'b0, 17, 0};
        tbl[6]  = '{3'd2, 64'h0003, 64'h0005, 64'hFFFE, 1'b0, 1, 10};
        tbl[7]  = '{3'd0, 64'h1234, 64'h0000, 64'h1234, 1'b0, 1, 0};
        tbl[8]  = '{3'd0, 64'h0001, 64'h0010, 64'h0000, 1'b1, 17, 0};
        tbl[9]  = '{3'd0, 64'h8000, 64'hFFF0, 64'h0000, 1'b1, 17, 0};
        tbl[10] = '{3'd3, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1, 0};
        tbl[11] = '{3'd5, 64'hA5A5, 64'h0F0F, 64'h0505, 1'b0, 1, 0};
        tbl[12] = '{3'd6, 64'h1200, 64'h0034, 64'h1234, 1'b0, 1, 0};
        tbl[13] = '{3'd7, 64'h00FF, 64'h1234, 64'hFF00, 1'b0, 1, 2};
        tbl[14] = '{3'd2, 64'h0005, 64'h0003, 64'h0002, 1'b1, 1, 0};
        tbl[15] = '{3'd0, 64'h0003, 64'hFFFE, 64'h0000, 1'b1, 3, 0};
        tbl[16] = '{3'd1, 64'hFFFF, 64'hFFFF, 64'h0001, 1'b1, 17, 1};
        tbl[17] = '{3'd4, 64'h7FFF, 64'h0001, 64'h8000, 1'b0, 1, 0};
        tbl[18] = '{3'd0, 64'h0001, 64'h000F, 64'h8000, 1'b0, 16, 0};
        tbl[19] = '{3'd0, 64'h8001, 64'h0011, 64'h0000, 1'b0, 17, 0};

        sel8 = 0; iv = 0; ordy = 0; op_d = 0; a_d = 0; b_d = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", ir16, 1);
        check("reset out_valid", ov16, 0);
        check("reset result", r16, 0);
        check("reset flags", {z16, n16, c16}, 0);
        check("reset8 in_ready/result", {ir8, r8}, 9'h100);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++)
            run_op(16, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].res,
                   tbl[i].c, tbl[i].lat, $sformatf("vec%0d", i));

        // Reset five cycles into a multiply: that result must never appear.
        sel8 = 0;
        @(negedge clk);
        iv = 1'b1; op_d = 3'd1; a_d = 64'h1234; b_d = 64'h5678;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        ov_seen = 0;
        repeat (4) begin
            if (ov16) ov_seen = 1;
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("abort in_ready", ir16, 1);
        check("abort result", r16, 0);
        repeat (25) begin
            @(negedge clk);
            if (ov16) ov_seen = 1;
        end
        check("abort out_valid", ov_seen, 0);
        run_op(16, 3'd4, 64'h2, 64'h3, 0, 64'h5, 1'b0, 1, "post_abort add");

        // Reset wins over an accept in the same cycle.
        @(negedge clk);
        iv = 1'b1; op_d = 3'd4; a_d = 64'h1; b_d = 64'h1; reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("reset priority", {ov16, ir16}, 2'b01);

        run_op(8, 3'd4, 64'hFF, 64'h01, 0, 64'h00, 1'b1, 1, "w8 add");
        run_op(8, 3'd0, 64'h81, 64'h08, 0, 64'h00, 1'b1, 9, "w8 shift");

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 64'($urandom_range(0, 16'hFFFF));
            rb = 64'($urandom_range(0, 16'hFFFF));
            if (rop == 3'd0 && $urandom_range(0, 2) != 0) begin
                rb = 64'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) rb = (~rb + 1) & 64'hFFFF;
            end
            model(16, rop, ra, rb, er, ec, el);
            run_op(16, rop, ra, rb, $urandom_range(0, 2), er, ec, el, $sformatf("rand16_%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 64'($urandom_range(0, 8'hFF));
            rb = 64'($urandom_range(0, 8'hFF));
            model(8, rop, ra, rb, er, ec, el);
            run_op(8, rop, ra, rb, $urandom_range(0, 1), er, ec, el, $sformatf("rand8_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
